// File: rtl/cache_pkg.sv
// Shared widths, the per-line storage record and address-field helpers for the
// direct-mapped cache model.
package cache_pkg;

  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 24;
  localparam int OFFSET_W = 3;
  localparam int INDEX_W  = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] word;
  } line_t;

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage: valid/tag/word per line, one synchronous write port and a
// combinational read port. Only the valid bits are cleared by rst.
module cache_line_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output line_t              rd_line_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  line_t              wr_line_i
);

  logic [LINES-1:0]  valid_vec;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] word_q [LINES];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      logic valid_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else if (wr_en_i && (wr_idx_i == INDEX_W'(gi))) begin
          valid_q <= wr_line_i.valid;
        end
      end
      assign valid_vec[gi] = valid_q;
    end
  endgenerate

  // Tag/word need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_line_i.tag;
      word_q[wr_idx_i] <= wr_line_i.word;
    end
  end

  assign rd_line_o.valid = valid_vec[rd_idx_i];
  assign rd_line_o.tag   = tag_q[rd_idx_i];
  assign rd_line_o.word  = word_q[rd_idx_i];

endmodule

// File: rtl/cache_processor.sv
// Direct-mapped write-allocate cache model with registered hit/miss response.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_processor
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              mode,
  output logic [DATA_W-1:0] out,
  output logic              status,
  output logic              addBlock
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tg;
  line_t              rd_line;
  line_t              wr_line;
  logic               hit;
  logic               is_write;
  logic               wr_en;
  logic [DATA_W-1:0]  out_d, out_q;
  logic               status_q;
  logic               add_block_q;

  assign idx = get_index(address);
  assign tg  = get_tag(address);

  cache_line_array u_lines (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (idx),
    .rd_line_o (rd_line),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx),
    .wr_line_i (wr_line)
  );

  always_comb begin
    hit      = rd_line.valid && (rd_line.tag == tg);
    // Only a definite 1 is a write; an unknown mode falls through as a read.
    is_write = (mode == 1'b1);
    wr_en    = is_write || !hit;
    wr_line  = '{valid: 1'b1, tag: tg, word: (is_write ? data : '0)};
    out_d    = '0;
    if (is_write) begin
      out_d = data;
    end else if (hit) begin
      out_d = rd_line.word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      status_q    <= 1'b0;
      add_block_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      status_q    <= hit;
      add_block_q <= !hit;
    end
  end

  assign out      = out_q;
  assign status   = status_q;
  assign addBlock = add_block_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (hit) begin
      if (hit_count_q != 32'hFFFF_FFFF) hit_count_q <= hit_count_q + 32'd1;
    end else begin
      if (miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_processor.sv
// Self-checking bench for cache_processor: directed scenarios followed by
// random accesses compared against an array-based behavioural cache model.
module tb_cache_processor;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] address;
  logic [23:0] data;
  logic        mode;
  logic [23:0] out;
  logic        status;
  logic        addBlock;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: one word per line, 16 lines, tag = address / 128.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [23:0] m_word  [16];
  int unsigned m_hits;
  int unsigned m_misses;

  always #5 clk = ~clk;

  cache_processor dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data     (data),
    .mode     (mode),
    .out      (out),
    .status   (status),
    .addBlock (addBlock)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst     = 1'b1;
    address = 24'($urandom);
    data    = 24'($urandom);
    mode    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    $display("[%0t] %s: reset out=%h status=%b addBlock=%b", $time, tag, out, status, addBlock);
    check({tag, ".out"},      32'(out),      32'h0);
    check({tag, ".status"},   32'(status),   32'h0);
    check({tag, ".addBlock"}, 32'(addBlock), 32'h0);
`ifdef CACHE_STATS_EN
    check({tag, ".hit_count"},  hit_count,  32'h0);
    check({tag, ".miss_count"}, miss_count, 32'h0);
`endif
  endtask

  // One access: predict from the model, drive, sample after the edge, compare.
  task automatic access(input logic [23:0] a, input logic [23:0] d, input bit w,
                        input string tag, output bit exp_hit, output logic [23:0] exp_out);
    int unsigned i;
    int unsigned t;
    i       = (int'(a) / 8) % 16;
    t       = int'(a) / 128;
    exp_hit = m_valid[i] && (m_tag[i] == t);
    if (w) begin
      m_word[i] = d;
      exp_out   = d;
    end else if (exp_hit) begin
      exp_out = m_word[i];
    end else begin
      m_word[i] = 24'h0;
      exp_out   = 24'h0;
    end
    m_valid[i] = 1'b1;
    m_tag[i]   = t;
    if (exp_hit) m_hits++;
    else         m_misses++;

    @(negedge clk);
    address = a;
    data    = d;
    mode    = w;
    @(posedge clk);
    #1;
    $display("[%0t] %s: %s addr=%h data=%h -> out=%h status=%b addBlock=%b", $time, tag,
             w ? "WR" : "RD", a, d, out, status, addBlock);
    check({tag, ".out"},      32'(out),      32'(exp_out));
    check({tag, ".status"},   32'(status),   32'(exp_hit));
    check({tag, ".addBlock"}, 32'(addBlock), 32'(!exp_hit));
`ifdef CACHE_STATS_EN
    check({tag, ".hit_count"},  hit_count,  m_hits);
    check({tag, ".miss_count"}, miss_count, m_misses);
`endif
  endtask

  initial begin
    bit          h;
    logic [23:0] o;
    logic [23:0] a;
    rst     = 1'b1;
    address = '0;
    data    = '0;
    mode    = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("init");

    // Cold read allocates a zero line, second read hits it.
    access(24'hABCDEF, 24'h0, 1'b0, "cold_rd", h, o);
    check("cold_rd.spec_status", 32'(status), 32'h0);
    access(24'hABCDEF, 24'h0, 1'b0, "warm_rd", h, o);
    check("warm_rd.spec_status", 32'(status), 32'h1);

    do_reset("rst_a");
    access(24'hABCDEF, 24'h123456, 1'b1, "cold_wr", h, o);
    check("cold_wr.spec_addBlock", 32'(addBlock), 32'h1);
    access(24'hABCDEF, 24'h0, 1'b0, "rd_after_wr", h, o);
    check("rd_after_wr.spec_out", 32'(out), 32'h123456);

    // Index-2 conflict: the read miss re-allocates and evicts the other tag.
    access(24'h567890, 24'h987654, 1'b1, "conf_wr1", h, o);
    access(24'h123490, 24'h133769, 1'b1, "conf_wr2", h, o);
    access(24'h567890, 24'h0, 1'b0, "conf_rd1", h, o);
    check("conf_rd1.spec_out", 32'(out), 32'h0);
    access(24'h123490, 24'h0, 1'b0, "conf_rd2", h, o);
    check("conf_rd2.spec_status", 32'(status), 32'h0);

    // Offset aliasing: same line, second write is a hit.
    access(24'h654321, 24'hFEDCBA, 1'b1, "alias_wr1", h, o);
    access(24'h654322, 24'h000001, 1'b1, "alias_wr2", h, o);
    check("alias_wr2.spec_status", 32'(status), 32'h1);
    access(24'h654321, 24'h0, 1'b0, "alias_rd", h, o);
    check("alias_rd.spec_out", 32'(out), 32'h000001);

    do_reset("rst_mid");
    access(24'hABCDEF, 24'h0, 1'b0, "post_rst_rd", h, o);
    check("post_rst_rd.spec_status", 32'(status), 32'h0);

    // Random traffic over a small tag pool so hits, misses and evictions all occur.
    for (int n = 0; n < 300; n++) begin
      a = {17'($urandom_range(0, 2) * 17'h0A5A5), 4'($urandom), 3'($urandom)};
      access(a, 24'($urandom), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n), h, o);
    end

`ifdef CACHE_STATS_EN
    do_reset("rst_stats");
    for (int n = 0; n < 50; n++) begin
      a = {17'(n + 1), 4'(n % 16), 3'b000};
      access(a, 24'(n * 3 + 1), 1'b1, $sformatf("pair_wr%0d", n), h, o);
      access(a, 24'h0, 1'b0, $sformatf("pair_rd%0d", n), h, o);
    end
    check("stats.spec_miss_count", miss_count, 32'd50);
    check("stats.spec_hit_count",  hit_count,  32'd50);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
